// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier for the EX-stage multiply path.
// Holds the pipeline stall while it retires BITS_PER_CYCLE multiplier bits per clock.
module mul_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mul_in,
  input  logic               mul_signed_in,
  input  logic               flush_in,
  input  logic [0:WIDTH-1]   a_in,
  input  logic [0:WIDTH-1]   b_in,
  input  logic [0:4]         fDestReg_in,
  output logic               stall_out,
  output logic               done,
  output logic               busy,
  output logic [0:2*WIDTH-1] result,
  output logic [0:4]         fDestReg_out
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t            stateReg, stateNext;
  logic [CW-1:0]     countReg;
  logic [PW-1:0]     accReg;
  logic [PW-1:0]     mcandReg;
  logic [WIDTH-1:0]  mplierReg;
  logic              negReg;
  logic [4:0]        destReg;
  logic [PW-1:0]     resultReg;
  logic [4:0]        destOutReg;

  logic [WIDTH-1:0]  aVal, bVal, aMag, bMag;
  logic              aNeg, bNeg;
  logic              capture;
  logic              lastIter;
  logic [PW-1:0]     partial [BITS_PER_CYCLE];
  logic [PW-1:0]     iterSum;
  logic [PW-1:0]     finalProduct;

  // Port bit 0 is the MSB, so a plain assignment lands it on aVal[WIDTH-1].
  assign aVal = a_in;
  assign bVal = b_in;
  assign aNeg = mul_signed_in & aVal[WIDTH-1];
  assign bNeg = mul_signed_in & bVal[WIDTH-1];
  assign aMag = aNeg ? -aVal : aVal;
  assign bMag = bNeg ? -bVal : bVal;

  assign capture  = (stateReg == IDLE) && mul_in && !flush_in;
  assign lastIter = (countReg == CW'(N - 1));

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : gPartial
      assign partial[gi] = mplierReg[gi] ? (mcandReg << gi) : '0;
    end
  endgenerate

  always_comb begin
    iterSum = accReg;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      iterSum = iterSum + partial[i];
    end
  end

  assign finalProduct = negReg ? -iterSum : iterSum;

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE: if (capture) stateNext = ITER;
      ITER: begin
        if (flush_in)      stateNext = IDLE;
        else if (lastIter) stateNext = DONE;
      end
      // The request is still high here, but it belongs to the finished instruction.
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg   <= IDLE;
      countReg   <= '0;
      accReg     <= '0;
      mcandReg   <= '0;
      mplierReg  <= '0;
      negReg     <= 1'b0;
      destReg    <= '0;
      resultReg  <= '0;
      destOutReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (capture) begin
        mcandReg  <= {{WIDTH{1'b0}}, aMag};
        mplierReg <= bMag;
        negReg    <= aNeg ^ bNeg;
        destReg   <= fDestReg_in;
        accReg    <= '0;
        countReg  <= '0;
      end else if (stateReg == ITER && !flush_in) begin
        accReg    <= iterSum;
        mcandReg  <= mcandReg << BITS_PER_CYCLE;
        mplierReg <= mplierReg >> BITS_PER_CYCLE;
        countReg  <= countReg + CW'(1);
        if (lastIter) begin
          resultReg  <= finalProduct;
          destOutReg <= destReg;
        end
      end
    end
  end

  assign done         = (stateReg == DONE);
  assign busy         = (stateReg == ITER);
  assign stall_out    = mul_in & ~done;
  assign result       = resultReg;
  assign fDestReg_out = destOutReg;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: default build plus BITS_PER_CYCLE=2/4 builds
// sharing one stimulus, checked against a behavioural multiply.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mul_in, mul_signed_in, flush_in;
  logic [0:31] a_in, b_in;
  logic [0:4]  fDestReg_in;

  logic        stall_out, done, busy;
  logic [0:63] result;
  logic [0:4]  fDestReg_out;
  logic        stall2, done2, busy2;
  logic [0:63] result2;
  logic [0:4]  fDest2;
  logic        stall4, done4, busy4;
  logic [0:63] result4;
  logic [0:4]  fDest4;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clk = ~clk;

  mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .mul_in(mul_in), .mul_signed_in(mul_signed_in),
    .flush_in(flush_in), .a_in(a_in), .b_in(b_in), .fDestReg_in(fDestReg_in),
    .stall_out(stall_out), .done(done), .busy(busy), .result(result),
    .fDestReg_out(fDestReg_out));

  mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .reset(reset), .mul_in(mul_in), .mul_signed_in(mul_signed_in),
    .flush_in(flush_in), .a_in(a_in), .b_in(b_in), .fDestReg_in(fDestReg_in),
    .stall_out(stall2), .done(done2), .busy(busy2), .result(result2),
    .fDestReg_out(fDest2));

  mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .mul_in(mul_in), .mul_signed_in(mul_signed_in),
    .flush_in(flush_in), .a_in(a_in), .b_in(b_in), .fDestReg_in(fDestReg_in),
    .stall_out(stall4), .done(done4), .busy(busy4), .result(result4),
    .fDestReg_out(fDest4));

  function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for done; counts stall cycles before it and scrambles inputs after capture.
  task automatic waitDone(output int stalls, output bit got, output logic firstBusy);
    stalls = 0; got = 0; firstBusy = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) firstBusy = busy;
      if (c == 1) begin
        a_in = $urandom; b_in = $urandom;
        mul_signed_in = ~mul_signed_in; fDestReg_in = ~fDestReg_in;
      end
      if (done) begin got = 1; break; end
      if (stall_out) stalls++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [4:0] dest, input logic [63:0] exp);
    int st; bit got; logic fb;
    a_in = a; b_in = b; mul_signed_in = s; fDestReg_in = dest; mul_in = 1'b1;
    waitDone(st, got, fb);
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_reqIdle"}, 64'(fb), 64'd0);
    check({tag, "_stalls"}, 64'(st), 64'd33);
    check({tag, "_result"}, result, exp);
    check({tag, "_dest"}, 64'(fDestReg_out), 64'(dest));
    check({tag, "_doneBusy"}, 64'(busy), 64'd0);
    $display("op %s a=%h b=%h signed=%0d -> result=%h dest=%0d stalls=%0d",
             tag, a, b, s, result, fDestReg_out, st);
  endtask

  // Drop the request in the cycle after DONE; done must have been a single pulse.
  task automatic finishOp(input string tag);
    @(posedge clk); #1 mul_in = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_noRestart"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int doneCount;
    int st2, st4;
    bit g1, g2, g4;
    logic [63:0] r2, r4, exp;
    logic [31:0] ra, rb;
    logic rs;

    reset = 1'b0; mul_in = 1'b0; mul_signed_in = 1'b0; flush_in = 1'b0;
    a_in = '0; b_in = '0; fDestReg_in = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 64'd0);
    check("rst_dest", 64'(fDestReg_out), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);
    #2 reset = 1'b1;

    @(posedge clk); #1;
    runOp("u3x5", 32'd3, 32'd5, 1'b0, 5'd7, 64'h0000_0000_0000_000F);
    finishOp("u3x5");
    @(posedge clk); #1;
    runOp("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd1, 64'hFFFF_FFFE_0000_0001);
    finishOp("umax");
    @(posedge clk); #1;
    runOp("sneg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFF1);
    finishOp("sneg3x5");
    @(posedge clk); #1;
    runOp("sminsq", 32'h8000_0000, 32'h8000_0000, 1'b1, 5'd31, 64'h4000_0000_0000_0000);
    finishOp("sminsq");
    @(posedge clk); #1;
    runOp("szero", 32'd0, 32'h8000_0000, 1'b1, 5'd2, 64'd0);
    finishOp("szero");

    // Back-to-back: the second request arrives in the first IDLE cycle after DONE.
    @(posedge clk); #1;
    runOp("b2b1", 32'd11, 32'd13, 1'b0, 5'd3, 64'd143);
    @(posedge clk); #1;
    runOp("b2b2", 32'd6, 32'd7, 1'b0, 5'd9, 64'h2A);
    finishOp("b2b2");

    // Flush in iteration 10.
    @(posedge clk); #1;
    a_in = 32'd9; b_in = 32'd9; mul_signed_in = 1'b0; fDestReg_in = 5'd4; mul_in = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 flush_in = 1'b1;
    @(negedge clk);
    check("flush_busyBefore", 64'(busy), 64'd1);
    @(posedge clk); #1 flush_in = 1'b0; mul_in = 1'b0;
    @(negedge clk);
    check("flush_idle", 64'(busy), 64'd0);
    doneCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    check("flush_noDone", 64'(doneCount), 64'd0);
    check("flush_resultKept", result, 64'h2A);
    check("flush_destKept", 64'(fDestReg_out), 64'd9);
    $display("flush at iteration 10: done pulses=%0d result=%h", doneCount, result);
    @(posedge clk); #1;
    runOp("postFlush", 32'd100, 32'd200, 1'b0, 5'd5, 64'd20000);
    finishOp("postFlush");

    // Asynchronous reset in iteration 20, checked before any further clock edge.
    @(posedge clk); #1;
    a_in = 32'd1234; b_in = 32'd5678; mul_signed_in = 1'b0; fDestReg_in = 5'd12; mul_in = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", result, 64'd0);
    check("arst_dest", 64'(fDestReg_out), 64'd0);
    mul_in = 1'b0;
    #4 reset = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    check("arst_noDone", 64'(doneCount), 64'd0);
    $display("reset at iteration 20: done pulses=%0d result=%h", doneCount, result);
    @(posedge clk); #1;
    runOp("postRst", 32'hFFFF_FFF9, 32'hFFFF_FFF7, 1'b1, 5'd17, 64'd63);
    finishOp("postRst");

    // Parameter sweep: all three builds see the same request.
    @(posedge clk); #1 flush_in = 1'b1;
    @(posedge clk); #1 flush_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ra = (k == 0) ? 32'h8000_0000 : 32'($urandom);
      rb = (k == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      rs = (k % 2 == 0);
      exp = refMul(ra, rb, rs);
      a_in = ra; b_in = rb; mul_signed_in = rs; fDestReg_in = 5'(k); mul_in = 1'b1;
      g1 = 0; g2 = 0; g4 = 0; st2 = -1; st4 = -1; r2 = '0; r4 = '0;
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        if (!g2 && done2) begin g2 = 1; st2 = c - 1; r2 = result2; end
        if (!g4 && done4) begin g4 = 1; st4 = c - 1; r4 = result4; end
        if (done) begin
          g1 = 1;
          check("sweep_bpc1_stalls", 64'(c - 1), 64'd33);
          check("sweep_bpc1_result", result, exp);
          break;
        end
      end
      check("sweep_bpc1_done", 64'(g1), 64'd1);
      check("sweep_bpc2_done", 64'(g2), 64'd1);
      check("sweep_bpc2_stalls", 64'(st2), 64'd17);
      check("sweep_bpc2_result", r2, exp);
      check("sweep_bpc4_done", 64'(g4), 64'd1);
      check("sweep_bpc4_stalls", 64'(st4), 64'd9);
      check("sweep_bpc4_result", r4, exp);
      $display("sweep %0d a=%h b=%h signed=%0d expect=%h bpc2=%h/%0d bpc4=%h/%0d",
               k, ra, rb, rs, exp, r2, st2, r4, st4);
      @(posedge clk); #1 mul_in = 1'b0; flush_in = 1'b1;
      @(posedge clk); #1 flush_in = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
